// File: rtl/hiscore_region_bridge.sv
// ============================================================================
// hiscore_region_bridge: high-score/NVRAM byte window onto up to four core-RAM
// regions. Optional core-write dirty tracking: HS_DIRTY_TRACK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hiscore_region_bridge #(
  parameter int          NUM_REGIONS  = 2,
  parameter int          RAM_AW       = 12,
  parameter logic [63:0] REGION_BASE  = {16'h0, 16'h0, 16'h057e, 16'h0620},
  parameter logic [63:0] REGION_LEN   = {16'h0, 16'h0, 16'h0003, 16'h0050},
  parameter int          SETUP_CYCLES = 2,
  parameter int          READ_LATENCY = 2,
  parameter logic [7:0]  FILL_BYTE    = 8'hff
) (
  input  logic              clk_74a,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [15:0]       req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_hit,
  output logic              ram_access,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        miss_count,
  input  logic              snoop_we,
  input  logic [RAM_AW-1:0] snoop_addr,
  input  logic              dirty_clr,
  output logic              dirty
);

  localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] WAIT_LOAD  = 4'(READ_LATENCY - 1);

  // Logical offset of a region: regions are packed back to back in order.
  function automatic logic [31:0] region_off(input int idx);
    logic [31:0] sum;
    sum = '0;
    for (int j = 0; j < 4; j++)
      if (j < idx) sum = sum + 32'(REGION_LEN[16*j +: 16]);
    return sum;
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [3:0]        w_region_hit;
  logic [RAM_AW-1:0] w_region_map [4];
  logic              w_hit_any;
  logic [RAM_AW-1:0] w_map_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_region
    localparam logic [31:0] OFF  = region_off(gi);
    localparam logic [31:0] LEN  = 32'(REGION_LEN[16*gi +: 16]);
    localparam logic [31:0] BASE = 32'(REGION_BASE[16*gi +: 16]);
    if (gi < NUM_REGIONS) begin : g_active
      assign w_region_hit[gi] = (32'(req_addr) >= OFF) && (32'(req_addr) < OFF + LEN);
      assign w_region_map[gi] = RAM_AW'(BASE + 32'(req_addr) - OFF);
    end else begin : g_unused
      assign w_region_hit[gi] = 1'b0;
      assign w_region_map[gi] = '0;
    end
  end

  // Scan downward so the lowest-numbered hit is the last one assigned.
  always_comb begin
    w_hit_any = |w_region_hit;
    w_map_sel = '0;
    for (int i = 3; i >= 0; i--)
      if (w_region_hit[i]) w_map_sel = w_region_map[i];
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_hit    <= 1'b0;
      ram_access <= 1'b0;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wdata  <= 8'h00;
      miss_count <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      ram_we    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_hit_any) begin
              r_state    <= S_SETUP;
              r_cnt      <= SETUP_LOAD;
              r_write    <= req_write;
              ram_addr   <= w_map_sel;
              ram_wdata  <= req_wdata;
              ram_access <= 1'b1;
              req_ready  <= 1'b0;
            end else begin
              if (miss_count != 8'hff) miss_count <= miss_count + 8'd1;
              if (!req_write) begin
                r_state   <= S_RESP;
                req_ready <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_hit   <= 1'b0;
                rsp_data  <= FILL_BYTE;
              end
            end
          end
        end
        S_SETUP: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_ISSUE;
            ram_we  <= r_write;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ISSUE: begin
          if (r_write) begin
            r_state    <= S_IDLE;
            ram_access <= 1'b0;
            req_ready  <= 1'b1;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= WAIT_LOAD;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state    <= S_RESP;
            ram_access <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_hit    <= 1'b1;
            rsp_data   <= ram_rdata;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          r_state    <= S_IDLE;
          ram_access <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef HS_DIRTY_TRACK_EN
  logic [3:0] w_snoop_hit;

  for (genvar gs = 0; gs < 4; gs++) begin : g_snoop
    localparam logic [31:0] LEN  = 32'(REGION_LEN[16*gs +: 16]);
    localparam logic [31:0] BASE = 32'(REGION_BASE[16*gs +: 16]);
    if (gs < NUM_REGIONS) begin : g_active
      assign w_snoop_hit[gs] = (32'(snoop_addr) >= BASE) && (32'(snoop_addr) < BASE + LEN);
    end else begin : g_unused
      assign w_snoop_hit[gs] = 1'b0;
    end
  end

  // A snooped strobe coinciding with our own ram_we is our write, not the core's.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n)
      dirty <= 1'b0;
    else if (snoop_we && !ram_we && |w_snoop_hit)
      dirty <= 1'b1;
    else if (dirty_clr)
      dirty <= 1'b0;
  end
`else
  logic unused_snoop;
  assign unused_snoop = ^{snoop_we, snoop_addr, dirty_clr};
  assign dirty        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hiscore_region_bridge.sv
// ============================================================================
// tb_hiscore_region_bridge: directed bench for hiscore_region_bridge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hiscore_region_bridge;

  logic        clk_74a = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_hit;
  logic [7:0]  rsp_data;
  logic        ram_access, ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata, miss_count;
  logic        snoop_we, dirty_clr, dirty;
  logic [11:0] snoop_addr;

  int compared   = 0;
  int mismatched = 0;
  int lat;
  logic seen;

  always #5 clk_74a = ~clk_74a;

  hiscore_region_bridge dut (
    .clk_74a(clk_74a), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .ram_access(ram_access), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .miss_count(miss_count),
    .snoop_we(snoop_we), .snoop_addr(snoop_addr), .dirty_clr(dirty_clr),
    .dirty(dirty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0;
    req_wdata = 8'h0; ram_rdata = 8'h0; snoop_we = 1'b0; snoop_addr = 12'h0;
    dirty_clr = 1'b0;
    repeat (2) @(negedge clk_74a);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_ram_access", 32'(ram_access), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_miss_count", 32'(miss_count), 32'd0);
    check("rst_dirty", 32'(dirty), 32'd0);
    reset_n = 1'b1;
    @(negedge clk_74a);

    // Hit read in region 1
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0051; ram_rdata = 8'h5a;
    @(negedge clk_74a);
    req_valid = 1'b0;
    check("rd51_access", 32'(ram_access), 32'd1);
    check("rd51_addr", 32'(ram_addr), 32'h57f);
    check("rd51_ready", 32'(req_ready), 32'd0);
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk_74a); lat++; end
    check("rd51_latency", 32'(lat), 32'd6);
    check("rd51_data", 32'(rsp_data), 32'h5a);
    check("rd51_hit", 32'(rsp_hit), 32'd1);
    check("rd51_access_fall", 32'(ram_access), 32'd0);
    @(negedge clk_74a);
    check("rd51_rsp_pulse", 32'(rsp_valid), 32'd0);
    check("rd51_ready_back", 32'(req_ready), 32'd1);
    check("rd51_data_hold", 32'(rsp_data), 32'h5a);

    // Hit write in region 0
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h004f; req_wdata = 8'h33;
    @(negedge clk_74a);
    req_valid = 1'b0;
    check("wr4f_setup1_we", 32'(ram_we), 32'd0);
    check("wr4f_setup1_addr", 32'(ram_addr), 32'h66f);
    check("wr4f_setup1_access", 32'(ram_access), 32'd1);
    @(negedge clk_74a);
    check("wr4f_setup2_we", 32'(ram_we), 32'd0);
    @(negedge clk_74a);
    check("wr4f_issue_we", 32'(ram_we), 32'd1);
    check("wr4f_issue_wdata", 32'(ram_wdata), 32'h33);
    check("wr4f_issue_addr", 32'(ram_addr), 32'h66f);
    @(negedge clk_74a);
    check("wr4f_after_we", 32'(ram_we), 32'd0);
    check("wr4f_after_ready", 32'(req_ready), 32'd1);
    check("wr4f_after_access", 32'(ram_access), 32'd0);

    // Read miss at TOTAL
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0053;
    @(negedge clk_74a);
    req_valid = 1'b0;
    check("rd53_valid", 32'(rsp_valid), 32'd1);
    check("rd53_data", 32'(rsp_data), 32'hff);
    check("rd53_hit", 32'(rsp_hit), 32'd0);
    check("rd53_access", 32'(ram_access), 32'd0);
    check("rd53_miss_count", 32'(miss_count), 32'd1);
    @(negedge clk_74a);
    check("rd53_rsp_pulse", 32'(rsp_valid), 32'd0);
    check("rd53_ready_back", 32'(req_ready), 32'd1);

    // Last byte of region 1
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0052; ram_rdata = 8'hc3;
    @(negedge clk_74a);
    req_valid = 1'b0;
    check("rd52_addr", 32'(ram_addr), 32'h580);
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk_74a); lat++; end
    check("rd52_latency", 32'(lat), 32'd6);
    check("rd52_data", 32'(rsp_data), 32'hc3);
    @(negedge clk_74a);

    // Back-to-back write misses saturate miss_count
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h8000; req_wdata = 8'h77;
    seen = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk_74a);
      if (ram_we || ram_access) seen = 1'b1;
      if (n == 253) check("wmiss_count_253", 32'(miss_count), 32'hfe);
    end
    req_valid = 1'b0;
    check("wmiss_saturated", 32'(miss_count), 32'hff);
    check("wmiss_no_ram", 32'(seen), 32'd0);
    check("wmiss_ready", 32'(req_ready), 32'd1);

    // Reset asserted while waiting on read data
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0000; ram_rdata = 8'h11;
    @(negedge clk_74a);
    req_valid = 1'b0;
    check("rd00_addr", 32'(ram_addr), 32'h620);
    repeat (3) @(negedge clk_74a);
    check("rd00_in_wait", 32'(ram_access), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_access", 32'(ram_access), 32'd0);
    check("abort_we", 32'(ram_we), 32'd0);
    check("abort_miss_count", 32'(miss_count), 32'd0);
    seen = 1'b0;
    repeat (3) begin @(negedge clk_74a); if (rsp_valid) seen = 1'b1; end
    reset_n = 1'b1;
    repeat (4) begin @(negedge clk_74a); if (rsp_valid) seen = 1'b1; end
    check("abort_no_rsp", 32'(seen), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_count_after", 32'(miss_count), 32'd0);

`ifdef HS_DIRTY_TRACK_EN
    check("dirty_start", 32'(dirty), 32'd0);
    snoop_we = 1'b1; snoop_addr = 12'h57e;
    @(negedge clk_74a);
    snoop_we = 1'b0;
    check("dirty_set_57e", 32'(dirty), 32'd1);
    dirty_clr = 1'b1;
    @(negedge clk_74a);
    dirty_clr = 1'b0;
    check("dirty_clr_alone1", 32'(dirty), 32'd0);
    snoop_we = 1'b1; snoop_addr = 12'h581;
    @(negedge clk_74a);
    snoop_we = 1'b0;
    check("dirty_out_581", 32'(dirty), 32'd0);
    snoop_we = 1'b1; snoop_addr = 12'h66f; dirty_clr = 1'b1;
    @(negedge clk_74a);
    snoop_we = 1'b0; dirty_clr = 1'b0;
    check("dirty_set_wins", 32'(dirty), 32'd1);
    dirty_clr = 1'b1;
    @(negedge clk_74a);
    dirty_clr = 1'b0;
    check("dirty_clr_alone2", 32'(dirty), 32'd0);
`else
    snoop_we = 1'b1; snoop_addr = 12'h57e;
    @(negedge clk_74a);
    snoop_we = 1'b0;
    check("dirty_tied_low", 32'(dirty), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
